// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_bridge
//  Description : Valid/ready request/response to APB3 master bridge with
//                2-bit slave-select decode. Optional ACCESS-phase watchdog
//                enabled by defining APB_MASTER_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_master_bridge #(
    parameter int DEC_LSB        = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    // request channel
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    // response channel
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        timeout,
    // APB bus
    output logic [31:0] PADDR,
    output logic        PWRITE,
    output logic        PSEL,
    output logic        PENABLE,
    output logic [31:0] PWDATA,
    output logic [1:0]  DECODE2BIT,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_SETUP  = 2'd1;
    localparam logic [1:0] c_S_ACCESS = 2'd2;
    localparam logic [1:0] c_S_RESP   = 2'd3;

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_timeout_range_err
        $error("apb_master_bridge: TIMEOUT_CYCLES must be in 1..65535");
    end

    if ((DEC_LSB < 0) || (DEC_LSB > 30)) begin : g_dec_lsb_range_err
        $error("apb_master_bridge: DEC_LSB must be in 0..30");
    end

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;

    logic        w_accept;
    logic        w_done;
    logic        w_abort;

    logic        w_psel_nxt;
    logic        w_penable_nxt;
    logic        w_req_ready_nxt;
    logic        w_rsp_valid_nxt;

    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic        r_timeout;
    logic [31:0] r_paddr;
    logic        r_pwrite;
    logic        r_psel;
    logic        r_penable;
    logic [31:0] r_pwdata;
    logic [1:0]  r_decode;

    // r_req_ready is only high in IDLE, so it doubles as the IDLE qualifier
    assign w_accept = (r_state == c_S_IDLE) && r_req_ready && req_valid;
    assign w_done   = (r_state == c_S_ACCESS) && PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_wait_cnt;

    // Abort on the TIMEOUT_CYCLES-th consecutive PREADY-low ACCESS cycle
    assign w_abort = (r_state == c_S_ACCESS) && !PREADY && (r_wait_cnt == c_TO_LAST);

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_wait_cnt <= 16'd0;
        end else if (r_state == c_S_SETUP) begin
            r_wait_cnt <= 16'd0;
        end else if ((r_state == c_S_ACCESS) && !PREADY) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
        end
    end
`else
    assign w_abort = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = c_S_SETUP;
                end
            end
            c_S_SETUP: begin
                w_state_nxt = c_S_ACCESS;
            end
            c_S_ACCESS: begin
                if (PREADY || w_abort) begin
                    w_state_nxt = c_S_RESP;
                end
            end
            c_S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic: decoded from the next state so every output is a flop
    // ------------------------------------------------------------------------
    always_comb begin
        w_psel_nxt      = 1'b0;
        w_penable_nxt   = 1'b0;
        w_req_ready_nxt = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        case (w_state_nxt)
            c_S_IDLE: begin
                w_req_ready_nxt = 1'b1;
            end
            c_S_SETUP: begin
                w_psel_nxt = 1'b1;
            end
            c_S_ACCESS: begin
                w_psel_nxt    = 1'b1;
                w_penable_nxt = 1'b1;
            end
            c_S_RESP: begin
                w_rsp_valid_nxt = 1'b1;
            end
            default: begin
                w_req_ready_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_timeout   <= 1'b0;
            r_paddr     <= 32'd0;
            r_pwrite    <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwdata    <= 32'd0;
            r_decode    <= 2'd0;
        end else begin
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_timeout   <= w_abort;

            if (w_accept) begin
                r_paddr  <= req_addr;
                r_pwrite <= req_write;
                r_pwdata <= req_wdata;
                r_decode <= req_addr[DEC_LSB+1:DEC_LSB];
            end

            // Read data is suppressed for writes and slave errors
            if (w_done) begin
                r_rsp_rdata <= (!r_pwrite && !PSLVERR) ? PRDATA : 32'd0;
                r_rsp_err   <= PSLVERR;
            end else if (w_abort) begin
                r_rsp_rdata <= 32'd0;
                r_rsp_err   <= 1'b1;
            end
        end
    end

    assign req_ready  = r_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_err    = r_rsp_err;
    assign PADDR      = r_paddr;
    assign PWRITE     = r_pwrite;
    assign PSEL       = r_psel;
    assign PENABLE    = r_penable;
    assign PWDATA     = r_pwdata;
    assign DECODE2BIT = r_decode;

`ifdef APB_MASTER_TIMEOUT_EN
    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_master_bridge
//  Description : Directed self-checking bench for apb_master_bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_bridge;

    logic        PCLK;
    logic        PRESETn;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        timeout;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PWDATA;
    logic [1:0]  DECODE2BIT;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int n_checks = 0;
    int n_errors = 0;

    apb_master_bridge #(
        .DEC_LSB        (12),
        .TIMEOUT_CYCLES (4)
    ) u_dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .timeout    (timeout),
        .PADDR      (PADDR),
        .PWRITE     (PWRITE),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWDATA     (PWDATA),
        .DECODE2BIT (DECODE2BIT),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs driven and outputs sampled 1ns after it
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic bus_state(input string tag, input logic psel, input logic pen,
                             input logic rv, input logic rr);
        check_val({tag, ".psel"},      {31'd0, PSEL},      {31'd0, psel});
        check_val({tag, ".penable"},   {31'd0, PENABLE},   {31'd0, pen});
        check_val({tag, ".rsp_valid"}, {31'd0, rsp_valid}, {31'd0, rv});
        check_val({tag, ".req_ready"}, {31'd0, req_ready}, {31'd0, rr});
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        PRESETn   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        rsp_ready = 1'b1;
        PRDATA    = 32'd0;
        PREADY    = 1'b1;
        PSLVERR   = 1'b0;

        // ---------------- reset values ----------------
        tick();
        tick();
        bus_state("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("rst.paddr",   PADDR,              32'd0);
        check_val("rst.pwdata",  PWDATA,             32'd0);
        check_val("rst.pwrite",  {31'd0, PWRITE},    32'd0);
        check_val("rst.decode",  {30'd0, DECODE2BIT}, 32'd0);
        check_val("rst.rdata",   rsp_rdata,          32'd0);
        check_val("rst.err",     {31'd0, rsp_err},   32'd0);
        check_val("rst.timeout", {31'd0, timeout},   32'd0);
        PRESETn = 1'b1;
        tick();
        check_val("rst.release_ready", {31'd0, req_ready}, 32'd1);

        // ---------------- zero-wait write ----------------
        issue(1'b1, 32'h0000_2004, 32'hDEAD_BEEF);
        PRDATA = 32'hAAAA_5555;
        tick();
        req_valid = 1'b0;
        bus_state("wr.setup", 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("wr.paddr",  PADDR,               32'h0000_2004);
        check_val("wr.pwdata", PWDATA,              32'hDEAD_BEEF);
        check_val("wr.pwrite", {31'd0, PWRITE},     32'd1);
        check_val("wr.decode", {30'd0, DECODE2BIT}, 32'd2);
        tick();
        bus_state("wr.access", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        bus_state("wr.resp", 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("wr.rdata", rsp_rdata,         32'd0);
        check_val("wr.err",   {31'd0, rsp_err},  32'd0);
        tick();
        bus_state("wr.idle", 1'b0, 1'b0, 1'b0, 1'b1);

        // ---------------- read with 3 wait states ----------------
        issue(1'b0, 32'h0000_3000, 32'h0);
        PREADY = 1'b0;
        tick();
        req_valid = 1'b0;
        bus_state("rdw.setup", 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("rdw.decode", {30'd0, DECODE2BIT}, 32'd3);
        tick();
        bus_state("rdw.access0", 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("rdw.paddr0", PADDR, 32'h0000_3000);
        for (int i = 0; i < 3; i++) begin
            tick();
            bus_state("rdw.wait", 1'b1, 1'b1, 1'b0, 1'b0);
            check_val("rdw.paddr_wait", PADDR, 32'h0000_3000);
            check_val("rdw.timeout", {31'd0, timeout}, 32'd0);
        end
        PREADY = 1'b1;
        PRDATA = 32'h1234_5678;
        tick();
        bus_state("rdw.resp", 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("rdw.rdata", rsp_rdata,        32'h1234_5678);
        check_val("rdw.err",   {31'd0, rsp_err}, 32'd0);
        tick();
        bus_state("rdw.idle", 1'b0, 1'b0, 1'b0, 1'b1);

        // ---------------- read with slave error ----------------
        issue(1'b0, 32'h0000_1008, 32'h0);
        PSLVERR = 1'b1;
        PRDATA  = 32'hFFFF_FFFF;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        bus_state("err.resp", 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("err.err",   {31'd0, rsp_err}, 32'd1);
        check_val("err.rdata", rsp_rdata,        32'd0);
        tick();
        PSLVERR = 1'b0;

        // ---------------- back-to-back with response stall ----------------
        rsp_ready = 1'b0;
        issue(1'b1, 32'h0000_0010, 32'h0000_0011);
        tick();
        issue(1'b0, 32'h0000_1ABC, 32'h0);
        check_val("b2b.paddr_setup", PADDR, 32'h0000_0010);
        tick();
        tick();
        bus_state("b2b.resp", 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("b2b.err_cleared", {31'd0, rsp_err}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            bus_state("b2b.stall", 1'b0, 1'b0, 1'b1, 1'b0);
            check_val("b2b.paddr_hold", PADDR, 32'h0000_0010);
        end
        rsp_ready = 1'b1;
        tick();
        bus_state("b2b.idle", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        req_valid = 1'b0;
        bus_state("b2b.setup2", 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("b2b.paddr2",  PADDR,               32'h0000_1ABC);
        check_val("b2b.pwrite2", {31'd0, PWRITE},     32'd0);
        check_val("b2b.decode2", {30'd0, DECODE2BIT}, 32'd1);
        PRDATA = 32'hCAFE_F00D;
        tick();
        tick();
        check_val("b2b.rdata2", rsp_rdata, 32'hCAFE_F00D);
        tick();

        // ---------------- reset during ACCESS ----------------
        issue(1'b1, 32'h0000_3FFC, 32'h5555_AAAA);
        PREADY = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        bus_state("mrst.access", 1'b1, 1'b1, 1'b0, 1'b0);
        PRESETn = 1'b0;
        tick();
        bus_state("mrst.in_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("mrst.paddr", PADDR, 32'd0);
        PRESETn = 1'b1;
        PREADY  = 1'b1;
        tick();
        bus_state("mrst.released", 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef APB_MASTER_TIMEOUT_EN
        // ---------------- watchdog abort ----------------
        issue(1'b0, 32'h0000_2000, 32'h0);
        PREADY = 1'b0;
        PRDATA = 32'h7777_7777;
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            bus_state("to.wait", 1'b1, 1'b1, 1'b0, 1'b0);
            check_val("to.no_pulse", {31'd0, timeout}, 32'd0);
        end
        tick();
        bus_state("to.resp", 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("to.pulse", {31'd0, timeout}, 32'd1);
        check_val("to.err",   {31'd0, rsp_err}, 32'd1);
        check_val("to.rdata", rsp_rdata,        32'd0);
        tick();
        check_val("to.pulse_end", {31'd0, timeout}, 32'd0);
        bus_state("to.idle", 1'b0, 1'b0, 1'b0, 1'b1);

        // ---------------- PREADY on terminal cycle wins ----------------
        issue(1'b0, 32'h0000_2000, 32'h0);
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            bus_state("tok.wait", 1'b1, 1'b1, 1'b0, 1'b0);
        end
        PREADY = 1'b1;
        PRDATA = 32'h5A5A_5A5A;
        tick();
        bus_state("tok.resp", 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("tok.no_pulse", {31'd0, timeout}, 32'd0);
        check_val("tok.err",      {31'd0, rsp_err}, 32'd0);
        check_val("tok.rdata",    rsp_rdata,        32'h5A5A_5A5A);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
